// File: rtl/v810_bus_pkg.sv
// -----------------------------------------------------------------------------
// v810_bus_pkg
//
// Shared definitions for V810 external-bus target blocks:
//   - bus_state_e   : bus-cycle sequencing states of a target
//   - WAIT_W        : width of the wait-state counter (0..15 wait states)
//   - lane_read     : steers a 32-bit memory word onto the CPU data lanes
//   - lane_wdata    : steers CPU write data onto the 32-bit memory port
//   - lane_be       : maps CPU byte enables (active-low) onto memory byte
//                     enables (active-high)
//
// The lane helpers are shared with narrow (8/16-bit) peripherals, so they
// take the bus width as an argument rather than a parameter.
// -----------------------------------------------------------------------------
package v810_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAITST = 2'd1,
        ST_REQ    = 2'd2,
        ST_RDY    = 2'd3
    } bus_state_e;

    localparam int WAIT_W = 4;

    // Read data as seen by the CPU. A 16-bit device always returns its
    // halfword on D[15:0]; A[1] picks which half of the stored word.
    function automatic logic [31:0] lane_read(
        input logic [31:0] word,
        input logic        a1,
        input logic        bus16
    );
        logic [31:0] res;
        if (bus16) begin
            res = {16'h0000, (a1 ? word[31:16] : word[15:0])};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Write data towards memory. A 16-bit device only gets D[15:0] from the
    // CPU, so the halfword is mirrored and the byte enables pick the half.
    function automatic logic [31:0] lane_wdata(
        input logic [31:0] data,
        input logic        bus16
    );
        logic [31:0] res;
        if (bus16) begin
            res = {data[15:0], data[15:0]};
        end else begin
            res = data;
        end
        return res;
    endfunction

    // Byte enables towards memory (active-high). For a 16-bit device only
    // BEn[1:0] are meaningful and are moved to the half selected by A[1].
    function automatic logic [3:0] lane_be(
        input logic [3:0] ben,
        input logic       a1,
        input logic       bus16
    );
        logic [3:0] res;
        if (bus16) begin
            res = a1 ? {~ben[1:0], 2'b00} : {2'b00, ~ben[1:0]};
        end else begin
            res = ~ben;
        end
        return res;
    endfunction

endpackage : v810_bus_pkg

// File: rtl/v810_bus_target.sv
// -----------------------------------------------------------------------------
// v810_bus_target
//
// Target (responder) side of the V810 external bus. Decodes an address
// window, inserts a fixed number of wait states, bridges the cycle to a
// req/ack memory port and answers the CPU with READYn (and SZRQn for a
// 16-bit device).
//
// Parameters
//   BASE, MASK : window select, hit when (A & MASK) == BASE
//   AW         : memory word-address width (MEM_A = A[AW+1:2])
//   WAIT       : extra CE cycles before the memory request (0..15)
//   BUS16      : 1 = behave as a 16-bit device
//
// Ports
//   CLK, RESn          : clock, asynchronous active-low reset
//   CE                 : bus-side clock enable
//   A, D_I, BEn, MRQn,
//   RW, BCYSTn, DAn    : CPU bus cycle inputs
//   D_O, READYn, SZRQn : responses to the CPU (registered)
//   MEM_A, MEM_WE,
//   MEM_BE, MEM_DI,
//   MEM_REQ            : memory request, held until MEM_ACK
//   MEM_DO, MEM_ACK    : memory response; MEM_ACK is a one-CLK pulse and
//                        does not follow CE
// -----------------------------------------------------------------------------
module v810_bus_target
    import v810_bus_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter logic [31:0] MASK  = 32'h8000_0000,
    parameter int          AW    = 20,
    parameter int          WAIT  = 0,
    parameter bit          BUS16 = 1'b0
) (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    input  logic [31:0]   A,
    input  logic [31:0]   D_I,
    output logic [31:0]   D_O,
    input  logic [3:0]    BEn,
    input  logic          MRQn,
    input  logic          RW,
    input  logic          BCYSTn,
    input  logic          DAn,
    output logic          READYn,
    output logic          SZRQn,
    output logic [AW-1:0] MEM_A,
    output logic          MEM_WE,
    output logic [3:0]    MEM_BE,
    output logic [31:0]   MEM_DI,
    input  logic [31:0]   MEM_DO,
    output logic          MEM_REQ,
    input  logic          MEM_ACK
);

    localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT);

    bus_state_e        state_q,   state_d;
    logic [WAIT_W-1:0] cnt_q,     cnt_d;
    logic              mem_req_q, mem_req_d;
    // Ack already taken from the memory port but not yet seen by a CE cycle.
    logic              ack_pend_q, ack_pend_d;
    logic              rw_q,      rw_d;
    logic              a1_q,      a1_d;
    logic [AW-1:0]     mem_a_q,   mem_a_d;
    logic              mem_we_q,  mem_we_d;
    logic [3:0]        mem_be_q,  mem_be_d;
    logic [31:0]       mem_di_q,  mem_di_d;
    logic [31:0]       d_o_q,     d_o_d;
    logic              ready_n_q, ready_n_d;
    logic              szrq_n_q,  szrq_n_d;

    logic              win_hit;
    logic              cycle_start;

    assign win_hit     = ((A & MASK) == BASE);
    assign cycle_start = CE && !BCYSTn && !MRQn && win_hit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        ack_pend_d = ack_pend_q;
        rw_d       = rw_q;
        a1_d       = a1_q;
        mem_a_d    = mem_a_q;
        mem_we_d   = mem_we_q;
        mem_be_d   = mem_be_q;
        mem_di_d   = mem_di_q;
        d_o_d      = d_o_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cycle_start) begin
                    rw_d       = RW;
                    a1_d       = A[1];
                    mem_a_d    = A[AW+1:2];
                    mem_we_d   = ~RW;
                    mem_be_d   = lane_be(BEn, A[1], BUS16);
                    ack_pend_d = 1'b0;
                    if (WAIT == 0) begin
                        state_d   = ST_REQ;
                        // Reads go out at once; writes wait for DAn.
                        mem_req_d = RW;
                    end else begin
                        state_d = ST_WAITST;
                        cnt_d   = WAIT_LD;
                    end
                end
            end

            ST_WAITST: begin
                if (CE) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAIT_W'(1)) begin
                        state_d   = ST_REQ;
                        mem_req_d = rw_q;
                    end
                end
            end

            ST_REQ: begin
                if (mem_req_q) begin
                    // The memory side runs on CLK, so the ack is taken (and
                    // the request dropped) whatever CE is doing.
                    if (MEM_ACK) begin
                        mem_req_d = 1'b0;
                        if (rw_q) begin
                            d_o_d = lane_read(MEM_DO, a1_q, BUS16);
                        end
                        if (CE) begin
                            state_d = ST_RDY;
                        end else begin
                            ack_pend_d = 1'b1;
                        end
                    end
                end else if (ack_pend_q) begin
                    if (CE) begin
                        state_d    = ST_RDY;
                        ack_pend_d = 1'b0;
                    end
                end else if (!rw_q && CE && !DAn) begin
                    // Write data is only valid once DAn is low.
                    mem_di_d  = lane_wdata(D_I, BUS16);
                    mem_req_d = 1'b1;
                end
            end

            ST_RDY: begin
                if (CE) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from the next state so READYn/SZRQn never depend
        // combinationally on bus inputs.
        ready_n_d = (state_d != ST_RDY);
        szrq_n_d  = !(BUS16 && (state_d == ST_RDY));
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            ack_pend_q <= 1'b0;
            rw_q       <= 1'b0;
            a1_q       <= 1'b0;
            mem_a_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'h0;
            mem_di_q   <= 32'h0;
            d_o_q      <= 32'h0;
            ready_n_q  <= 1'b1;
            szrq_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            ack_pend_q <= ack_pend_d;
            rw_q       <= rw_d;
            a1_q       <= a1_d;
            mem_a_q    <= mem_a_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_di_q   <= mem_di_d;
            d_o_q      <= d_o_d;
            ready_n_q  <= ready_n_d;
            szrq_n_q   <= szrq_n_d;
        end
    end

    assign D_O     = d_o_q;
    assign READYn  = ready_n_q;
    assign SZRQn   = szrq_n_q;
    assign MEM_A   = mem_a_q;
    assign MEM_WE  = mem_we_q;
    assign MEM_BE  = mem_be_q;
    assign MEM_DI  = mem_di_q;
    assign MEM_REQ = mem_req_q;

endmodule : v810_bus_target
